// File: rtl/eightbit_fifo.sv
// eightbit_fifo: count-based valid/ready FIFO buffering messages between the register stage and its consumer
module eightbit_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enq_val,
    output logic                     enq_rdy,
    input  logic [WIDTH-1:0]         enq_msg,
    output logic                     deq_val,
    input  logic                     deq_rdy,
    output logic [WIDTH-1:0]         deq_msg,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic full, empty, enq_fire, deq_fire;
    always_comb begin
        full     = count == (AW+1)'(DEPTH);
        empty    = count == '0;
        enq_rdy  = !full && !reset;
        deq_val  = !empty && !reset;
        enq_fire = enq_val && enq_rdy;
        deq_fire = deq_val && deq_rdy;
        deq_msg  = deq_val ? mem[rd_ptr] : '0;
    end
    // storage is never cleared; only pointers and occupancy reset
    always_ff @(posedge clk)
        if (enq_fire) mem[wr_ptr] <= enq_msg;
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_fire) wr_ptr <= wr_ptr + AW'(1);
            if (deq_fire) rd_ptr <= rd_ptr + AW'(1);
            count <= enq_fire && !deq_fire ? count + (AW+1)'(1) :
                     deq_fire && !enq_fire ? count - (AW+1)'(1) : count;
        end
    end
`ifdef FORMAL
    logic f_past_valid = 1'b0;
    always @(posedge clk) f_past_valid <= 1'b1;
    always @(*) begin
        assert (count <= (AW+1)'(DEPTH));
        assert (!(enq_rdy && full));
        assert (!(deq_val && empty));
    end
    always @(posedge clk)
        if (f_past_valid && !$past(reset))
            assert (count == $past(count) + (AW+1)'($past(enq_fire)) - (AW+1)'($past(deq_fire)));
`endif
endmodule

// File: tb/tb_eightbit_fifo.sv
// tb_eightbit_fifo: directed self-checking bench for eightbit_fifo (DEPTH=4, WIDTH=8)
module tb_eightbit_fifo;
    logic clk = 1'b0;
    logic reset, enq_val, enq_rdy, deq_val, deq_rdy;
    logic [7:0] enq_msg, deq_msg;
    logic [2:0] count;
    int n_cmp = 0;
    int n_bad = 0;
    eightbit_fifo #(.DEPTH(4), .WIDTH(8)) dut (
        .clk(clk), .reset(reset), .enq_val(enq_val), .enq_rdy(enq_rdy), .enq_msg(enq_msg),
        .deq_val(deq_val), .deq_rdy(deq_rdy), .deq_msg(deq_msg), .count(count)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    initial begin
        reset = 1'b1; enq_val = 1'b0; deq_rdy = 1'b0; enq_msg = 8'h00;
        step;
        check("rst_enq_rdy", enq_rdy, 0);
        check("rst_deq_val", deq_val, 0);
        step;
        reset = 1'b0;
        step;
        check("idle_enq_rdy", enq_rdy, 1);
        check("idle_deq_val", deq_val, 0);
        check("idle_count", count, 0);
        check("idle_deq_msg", deq_msg, 0);
        enq_val = 1'b1; enq_msg = 8'hA5;
        step;
        enq_val = 1'b0;
        check("single_val", deq_val, 1);
        check("single_msg", deq_msg, 8'hA5);
        check("single_count", count, 1);
        deq_rdy = 1'b1;
        step;
        deq_rdy = 1'b0;
        check("single_drain_val", deq_val, 0);
        check("single_drain_count", count, 0);
        check("single_drain_msg", deq_msg, 0);
        for (int i = 1; i <= 5; i++) begin
            enq_val = 1'b1; enq_msg = 8'(i);
            check("fill_enq_rdy", enq_rdy, i <= 4);
            step;
        end
        check("full_count", count, 4);
        check("full_enq_rdy", enq_rdy, 0);
        check("full_head", deq_msg, 8'h01);
        deq_rdy = 1'b1;
        check("drain0_msg", deq_msg, 8'h01);
        step;
        check("full_deq_only_count", count, 3);
        check("drain1_enq_rdy", enq_rdy, 1);
        check("drain1_msg", deq_msg, 8'h02);
        step;
        enq_val = 1'b0;
        check("both_fire_count", count, 3);
        for (int i = 3; i <= 5; i++) begin
            check("drain_msg", deq_msg, 8'(i));
            step;
            check("drain_count", count, 32'(5 - i));
        end
        check("drain_empty_val", deq_val, 0);
        enq_val = 1'b1; deq_rdy = 1'b1;
        for (int c = 0; c < 20; c++) begin
            enq_msg = 8'(c);
            check("stream_val", deq_val, c > 0);
            if (c > 0) check("stream_msg", deq_msg, 8'(c - 1));
            step;
            check("stream_count", count, 1);
        end
        enq_val = 1'b0;
        check("stream_last", deq_msg, 8'd19);
        step;
        check("stream_end_count", count, 0);
        deq_rdy = 1'b0; enq_val = 1'b1;
        for (int i = 0; i < 3; i++) begin
            enq_msg = 8'(8'h10 + i);
            step;
        end
        check("pre_reset_count", count, 3);
        reset = 1'b1; enq_msg = 8'h77;
        #1;
        check("reset_enq_rdy", enq_rdy, 0);
        check("reset_deq_val", deq_val, 0);
        step;
        reset = 1'b0; enq_val = 1'b0;
        check("post_reset_count", count, 0);
        check("post_reset_val", deq_val, 0);
        enq_val = 1'b1; enq_msg = 8'h3C;
        step;
        enq_val = 1'b0;
        check("post_reset_head", deq_msg, 8'h3C);
        check("post_reset_count1", count, 1);
        deq_rdy = 1'b1;
        step;
        deq_rdy = 1'b0;
        check("final_count", count, 0);
        check("final_val", deq_val, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
